// File: rtl/button_debounce.sv
// Per-channel button conditioner: polarity normalisation, 2-flop synchroniser,
// counter-based debounce, and registered press/release/long-press event pulses.
module button_debounce #(
  parameter int N_BTN           = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int LCW = $clog2(LONG_CYCLES + 1);

  localparam logic [DCW-1:0] D_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCW-1:0] H_LAST = LCW'(LONG_CYCLES - 1);
  localparam logic [LCW-1:0] H_MAX  = LCW'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must be >= 1");
  end

  logic [N_BTN-1:0] pressed_raw;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [DCW-1:0]   dcnt [N_BTN];
  logic [LCW-1:0]   hcnt [N_BTN];

  assign pressed_raw = i_btn ^ {N_BTN{ACTIVE_LOW}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pressed_raw;
      s2 <= s1;
    end
  end

  // o_btn is the accepted state; events are registered alongside it so they
  // line up with the cycle in which o_btn changes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_btn     <= '0;
      o_press   <= '0;
      o_release <= '0;
      o_long    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        o_press[i]   <= 1'b0;
        o_release[i] <= 1'b0;
        o_long[i]    <= 1'b0;

        if (s2[i] == o_btn[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == D_LAST) begin
          dcnt[i]      <= '0;
          o_btn[i]     <= s2[i];
          o_press[i]   <= s2[i];
          o_release[i] <= ~s2[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end

        // A release accepted on the same edge suppresses a coincident long pulse.
        if (!o_btn[i]) begin
          hcnt[i] <= '0;
        end else begin
          if (hcnt[i] != H_MAX) begin
            hcnt[i] <= hcnt[i] + 1'b1;
          end
          if ((hcnt[i] == H_LAST) && !((s2[i] != o_btn[i]) && (dcnt[i] == D_LAST))) begin
            o_long[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce with short debounce/long windows.
module tb_button_debounce;

  localparam int N_BTN = 4;
  localparam int DC    = 4;
  localparam int LC    = 10;

  logic             i_clk;
  logic             i_rst_n;
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_btn;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_long;
  logic [15:0]      obs;

  int vectors;
  int miscompares;

  button_debounce #(
    .N_BTN(N_BTN),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES(LC)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_btn(i_btn),
    .o_btn(o_btn),
    .o_press(o_press),
    .o_release(o_release),
    .o_long(o_long)
  );

  // Observed bundle: {o_btn, o_press, o_release, o_long}
  assign obs = {o_btn, o_press, o_release, o_long};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_btn   = 4'hF;
    i_rst_n = 1'b1;
    #1;
    i_rst_n = 1'b0;
    #1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      vectors++;
      if (obs !== 16'h0000) begin
        $display("[TB] FAIL reset_hold t=%0d: got %h expected %h", t, obs, 16'h0000);
        miscompares++;
      end
    end
    i_rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      vectors++;
      if (obs !== 16'h0000) begin
        $display("[TB] FAIL reset_idle t=%0d: got %h expected %h", t, obs, 16'h0000);
        miscompares++;
      end
    end
  endtask

  task automatic test_press();
    logic [15:0] exp;
    i_btn[0] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = 16'h0000;
      if (t >= 6) exp[15:12] = 4'b0001;
      if (t == 6) exp[11:8]  = 4'b0001;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL press t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    #3;
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("[TB] FAIL reset_async: got %h expected %h", obs, 16'h0000);
      miscompares++;
    end
    for (int t = 1; t <= 3; t++) begin
      tick();
      vectors++;
      if (obs !== 16'h0000) begin
        $display("[TB] FAIL reset_mid_hold t=%0d: got %h expected %h", t, obs, 16'h0000);
        miscompares++;
      end
    end
    i_rst_n = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = 16'h0000;
      if (t >= 6) exp[15:12] = 4'b0001;
      if (t == 6) exp[11:8]  = 4'b0001;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL held_through_reset t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
    i_btn[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = 16'h0000;
      if (t <= 5) exp[15:12] = 4'b0001;
      if (t == 6) exp[7:4]   = 4'b0001;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL release0 t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_glitch();
    logic [15:0] exp;
    i_btn[1] = 1'b0;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 3) i_btn[1] = 1'b1;
      vectors++;
      if (obs !== 16'h0000) begin
        $display("[TB] FAIL glitch t=%0d: got %h expected %h", t, obs, 16'h0000);
        miscompares++;
      end
    end
    i_btn[1] = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t == 4) i_btn[1] = 1'b1;
      exp = 16'h0000;
      if (t >= 6 && t <= 9) exp[15:12] = 4'b0010;
      if (t == 6)           exp[11:8]  = 4'b0010;
      if (t == 10)          exp[7:4]   = 4'b0010;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL min_press t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] exp;
    for (int ph = 0; ph < 20; ph++) begin
      i_btn[2] = ph[0];
      for (int t = 1; t <= 2; t++) begin
        tick();
        vectors++;
        if (obs !== 16'h0000) begin
          $display("[TB] FAIL bounce ph=%0d t=%0d: got %h expected %h", ph, t, obs, 16'h0000);
          miscompares++;
        end
      end
    end
    i_btn[2] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = 16'h0000;
      if (t >= 6) exp[15:12] = 4'b0100;
      if (t == 6) exp[11:8]  = 4'b0100;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL bounce_settle t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
    i_btn[2] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = 16'h0000;
      if (t <= 5) exp[15:12] = 4'b0100;
      if (t == 6) exp[7:4]   = 4'b0100;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL bounce_release t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_long();
    logic [15:0] exp;
    i_btn[3] = 1'b0;
    for (int t = 1; t <= 116; t++) begin
      tick();
      exp = 16'h0000;
      if (t >= 6)      exp[15:12] = 4'b1000;
      if (t == 6)      exp[11:8]  = 4'b1000;
      if (t == 6 + LC) exp[3:0]   = 4'b1000;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL long_hold t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
    i_btn[3] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = 16'h0000;
      if (t <= 5) exp[15:12] = 4'b1000;
      if (t == 6) exp[7:4]   = 4'b1000;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL long_release t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
    i_btn[3] = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (t == 6) i_btn[3] = 1'b1;
      exp = 16'h0000;
      if (t >= 6 && t <= 11) exp[15:12] = 4'b1000;
      if (t == 6)            exp[11:8]  = 4'b1000;
      if (t == 12)           exp[7:4]   = 4'b1000;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL short_hold t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    i_btn = 4'b0110;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = 16'h0000;
      if (t >= 6) exp[15:12] = 4'b1001;
      if (t == 6) exp[11:8]  = 4'b1001;
      vectors++;
      if (obs !== exp) begin
        $display("[TB] FAIL simultaneous t=%0d: got %h expected %h", t, obs, exp);
        miscompares++;
      end
    end
    i_btn[1] = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      tick();
      vectors++;
      if (obs !== 16'h9000) begin
        $display("[TB] FAIL mid_debounce t=%0d: got %h expected %h", t, obs, 16'h9000);
        miscompares++;
      end
    end
    #3;
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 16'h0000) begin
      $display("[TB] FAIL reset_debounce: got %h expected %h", obs, 16'h0000);
      miscompares++;
    end
    i_btn = 4'hF;
    tick();
    tick();
    i_rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      vectors++;
      if (obs !== 16'h0000) begin
        $display("[TB] FAIL after_reset t=%0d: got %h expected %h", t, obs, 16'h0000);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_btn       = 4'hF;
    i_rst_n     = 1'b1;
    test_reset();
    test_press();
    test_reset_mid();
    test_glitch();
    test_bounce();
    test_long();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
